// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR generator: feedback modes and default tap masks.
package lfsr_pkg;

  typedef enum logic {
    LFSR_FIB = 1'b0,
    LFSR_GAL = 1'b1
  } lfsr_mode_e;

  // Maximal-length tap masks; the top bit is always set so the full width is used.
  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hB400;
  localparam logic [31:0] TAPS_32 = 32'h8020_0003;

endpackage

// File: rtl/lfsr_gen_if.sv
// Control and data bundle between the LFSR generator and its consumer.
interface lfsr_gen_if #(
  parameter int WIDTH = 8
);

  logic             en;
  logic             load;
  logic [WIDTH-1:0] seed_in;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] step_cnt;
  logic             period_done;
  logic             lockup;

  // Side that controls the generator and consumes its output.
  modport master (
    output en, load, seed_in, out_ready,
    input  out_data, out_valid, step_cnt, period_done, lockup
  );

  // The generator itself.
  modport slave (
    input  en, load, seed_in, out_ready,
    output out_data, out_valid, step_cnt, period_done, lockup
  );

endinterface

// File: rtl/lfsr_next.sv
// Pure combinational next-state function for a Fibonacci or Galois LFSR.
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter lfsr_mode_e       MODE  = LFSR_FIB
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next
);

  // Fibonacci shifts left and feeds back the parity of the tapped bits;
  // Galois shifts right and folds the tap mask in when a one falls out.
  always_comb begin
    next = '0;
    if (MODE == LFSR_FIB) begin
      next = {state[WIDTH-2:0], ^(state & TAPS)};
    end else begin
      next = (state >> 1) ^ (state[0] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/lfsr_gen.sv
// LFSR sequence generator with valid/ready output, seed load, period
// detection and automatic recovery from the all-zero lock-up state.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter lfsr_mode_e       MODE  = LFSR_FIB,
  parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
  input logic       clk,
  input logic       rst,
  lfsr_gen_if.slave bus
);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] step_cnt;
  logic [WIDTH-1:0] next_state;
  logic             out_valid;
  logic             period_done;
  logic             lockup;
  logic             transfer;
  logic             zero_state;

  lfsr_next #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .MODE  (MODE)
  ) u_next (
    .state (state),
    .next  (next_state)
  );

  assign transfer   = out_valid & bus.out_ready & bus.en;
  assign zero_state = (state == '0);

  // Sequence state, period tracking and flag pulses; load beats recovery,
  // recovery beats a normal step, and lockup is flagged even when load wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SEED;
      start_val   <= SEED;
      step_cnt    <= '0;
      out_valid   <= 1'b0;
      period_done <= 1'b0;
      lockup      <= 1'b0;
    end else begin
      out_valid   <= 1'b1;
      period_done <= 1'b0;
      lockup      <= zero_state;
      if (bus.load) begin
        state     <= bus.seed_in;
        start_val <= bus.seed_in;
        step_cnt  <= '0;
      end else if (zero_state) begin
        state     <= SEED;
        start_val <= SEED;
        step_cnt  <= '0;
      end else if (transfer) begin
        state <= next_state;
        if (next_state == start_val) begin
          period_done <= 1'b1;
          step_cnt    <= '0;
        end else begin
          step_cnt <= step_cnt + WIDTH'(1);
        end
      end
    end
  end

  assign bus.out_data    = state;
  assign bus.out_valid   = out_valid;
  assign bus.step_cnt    = step_cnt;
  assign bus.period_done = period_done;
  assign bus.lockup      = lockup;

endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench for lfsr_gen: a Fibonacci and a Galois instance share the
// same stimulus; expected responses are queued and checked by a monitor.
module tb_lfsr_gen;
  import lfsr_pkg::*;

  typedef struct {
    logic [7:0] data;
    logic [7:0] cnt;
    logic       pd;
    logic       lock;
    logic       gchk;
    logic [7:0] gdata;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   idx;
  exp_t q[$];
  exp_t mon;

  lfsr_gen_if #(.WIDTH(8)) fif ();
  lfsr_gen_if #(.WIDTH(8)) gif ();

  lfsr_gen #(
    .WIDTH (8),
    .TAPS  (8'hB8),
    .MODE  (LFSR_FIB),
    .SEED  (8'h01)
  ) dutFib (
    .clk (clk),
    .rst (rst),
    .bus (fif)
  );

  lfsr_gen #(
    .WIDTH (8),
    .TAPS  (8'hB8),
    .MODE  (LFSR_GAL),
    .SEED  (8'h01)
  ) dutGal (
    .clk (clk),
    .rst (rst),
    .bus (gif)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] fibNext(input logic [7:0] s);
    return {s[6:0], ^(s & 8'hB8)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs to both instances, queue the expected response
  // for the coming edge, then move on to the next falling edge.
  task automatic applyStimulus(input logic e, input logic r, input logic l, input logic [7:0] s,
                               input logic [7:0] d, input logic [7:0] c, input logic pd,
                               input logic lk, input logic gchk, input logic [7:0] gd);
    exp_t x;
    fif.en = e;  fif.out_ready = r;  fif.load = l;  fif.seed_in = s;
    gif.en = e;  gif.out_ready = r;  gif.load = l;  gif.seed_in = s;
    x.data = d;  x.cnt = c;  x.pd = pd;  x.lock = lk;  x.gchk = gchk;  x.gdata = gd;
    q.push_back(x);
    @(negedge clk);
  endtask

  // Monitor: shortly after each rising edge, compare any queued expectation.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon = q.pop_front();
      idx++;
      checkOutput($sformatf("fib_valid[%0d]", idx), fif.out_valid, 1'b1);
      checkOutput($sformatf("fib_data[%0d]", idx), fif.out_data, mon.data);
      checkOutput($sformatf("fib_cnt[%0d]", idx), fif.step_cnt, mon.cnt);
      checkOutput($sformatf("fib_period_done[%0d]", idx), fif.period_done, mon.pd);
      checkOutput($sformatf("fib_lockup[%0d]", idx), fif.lockup, mon.lock);
      if (mon.gchk) begin
        checkOutput($sformatf("gal_data[%0d]", idx), gif.out_data, mon.gdata);
        checkOutput($sformatf("gal_cnt[%0d]", idx), gif.step_cnt, mon.cnt);
      end
    end
  end

  // Directed test sequence.
  initial begin
    logic [7:0] m;
    int         waitCycles;
    checks = 0;
    errors = 0;
    idx    = 0;
    rst    = 1'b1;
    fif.en = 1'b0; fif.out_ready = 1'b0; fif.load = 1'b0; fif.seed_in = 8'h00;
    gif.en = 1'b0; gif.out_ready = 1'b0; gif.load = 1'b0; gif.seed_in = 8'h00;
    repeat (2) @(negedge clk);

    checkOutput("reset_data", fif.out_data, 8'h01);
    checkOutput("reset_valid", fif.out_valid, 1'b0);
    checkOutput("reset_cnt", fif.step_cnt, 8'h00);
    checkOutput("reset_pd", fif.period_done, 1'b0);
    checkOutput("reset_lockup", fif.lockup, 1'b0);
    checkOutput("reset_gal_data", gif.out_data, 8'h01);

    rst = 1'b0;
    // First edge only raises out_valid; steps follow on later edges.
    applyStimulus(1, 1, 0, 8'h00, 8'h01, 8'd0, 0, 0, 1, 8'h01);
    applyStimulus(1, 1, 0, 8'h00, 8'h02, 8'd1, 0, 0, 1, 8'hB8);
    applyStimulus(1, 1, 0, 8'h00, 8'h04, 8'd2, 0, 0, 1, 8'h5C);
    applyStimulus(1, 1, 0, 8'h00, 8'h08, 8'd3, 0, 0, 1, 8'h2E);
    applyStimulus(1, 1, 0, 8'h00, 8'h11, 8'd4, 0, 0, 1, 8'h17);
    applyStimulus(1, 1, 0, 8'h00, 8'h23, 8'd5, 0, 0, 1, 8'hB3);

    // Full period from seed 01: period_done on the 255th step only.
    applyStimulus(1, 1, 1, 8'h01, 8'h01, 8'd0, 0, 0, 0, 8'h00);
    m = 8'h01;
    for (int k = 1; k <= 255; k++) begin
      m = fibNext(m);
      applyStimulus(1, 1, 0, 8'h00, m, (k == 255) ? 8'd0 : k[7:0], (k == 255), 0, 0, 8'h00);
    end
    applyStimulus(1, 1, 0, 8'h00, 8'h02, 8'd1, 0, 0, 0, 8'h00);

    // Ready pattern 1,0,0,1, then enable low with ready high.
    applyStimulus(1, 1, 1, 8'h01, 8'h01, 8'd0, 0, 0, 0, 8'h00);
    applyStimulus(1, 1, 0, 8'h00, 8'h02, 8'd1, 0, 0, 0, 8'h00);
    applyStimulus(1, 0, 0, 8'h00, 8'h02, 8'd1, 0, 0, 0, 8'h00);
    applyStimulus(1, 0, 0, 8'h00, 8'h02, 8'd1, 0, 0, 0, 8'h00);
    applyStimulus(1, 1, 0, 8'h00, 8'h04, 8'd2, 0, 0, 0, 8'h00);
    applyStimulus(0, 1, 0, 8'h00, 8'h04, 8'd2, 0, 0, 0, 8'h00);

    // Load wins over a pending transfer.
    applyStimulus(1, 1, 1, 8'h5A, 8'h5A, 8'd0, 0, 0, 0, 8'h00);
    applyStimulus(1, 1, 0, 8'h00, 8'hB4, 8'd1, 0, 0, 0, 8'h00);

    // Zero seed: recovery to SEED with a lockup pulse.
    applyStimulus(1, 1, 1, 8'h00, 8'h00, 8'd0, 0, 0, 0, 8'h00);
    applyStimulus(1, 1, 0, 8'h00, 8'h01, 8'd0, 0, 1, 0, 8'h00);
    applyStimulus(1, 1, 0, 8'h00, 8'h02, 8'd1, 0, 0, 0, 8'h00);

    // Recovery happens even with enable low.
    applyStimulus(1, 1, 1, 8'h00, 8'h00, 8'd0, 0, 0, 0, 8'h00);
    applyStimulus(0, 0, 0, 8'h00, 8'h01, 8'd0, 0, 1, 0, 8'h00);

    // Load during a zero state wins but lockup still pulses.
    applyStimulus(1, 1, 1, 8'h00, 8'h00, 8'd0, 0, 0, 0, 8'h00);
    applyStimulus(1, 1, 1, 8'h33, 8'h33, 8'd0, 0, 1, 0, 8'h00);
    applyStimulus(1, 1, 0, 8'h00, 8'h66, 8'd1, 0, 0, 0, 8'h00);

    waitCycles = 0;
    while (q.size() > 0 && waitCycles < 10) begin
      @(posedge clk);
      waitCycles++;
    end
    #2;
    checkOutput("queue_drained", q.size(), 0);

    // Asynchronous reset mid-cycle with load and a transfer pending.
    @(negedge clk);
    fif.load = 1'b1; fif.seed_in = 8'h77; fif.en = 1'b1; fif.out_ready = 1'b1;
    gif.load = 1'b1; gif.seed_in = 8'h77; gif.en = 1'b1; gif.out_ready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_data", fif.out_data, 8'h01);
    checkOutput("async_rst_valid", fif.out_valid, 1'b0);
    checkOutput("async_rst_cnt", fif.step_cnt, 8'h00);
    checkOutput("async_rst_gal_data", gif.out_data, 8'h01);
    @(negedge clk);
    checkOutput("rst_hold_data", fif.out_data, 8'h01);
    checkOutput("rst_hold_valid", fif.out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
